acc_src_mux: RTL and testbench

//   Parametrised accumulator-source selector and accumulator register for the calculator datapath.

---
 rtl/acc_src_mux.sv | 205 ++++++++++++++++++++
 tb/tb_acc_src_mux.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/acc_src_mux.sv
// acc_src_mux: accumulator-source selector and accumulator register.
// A command selects what the accumulator is loaded with (input register,
// ALU result, decimal digit append, or zero). Non-CLEAR commands wait for
// their source to present valid data, then commit on the following cycle,
// raising outDone for exactly one clock with the new accumulator value.
module acc_src_mux #(
  parameter int IN_W       = 4,
  parameter int ACC_W      = 16,
  parameter int RADIX      = 10,
  parameter int MAX_DIGITS = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              inStart,
  input  logic [1:0]                        inSelect,
  input  logic [IN_W-1:0]                   inReg,
  input  logic                              inRegValid,
  input  logic [ACC_W-1:0]                  inAlu,
  input  logic                              inAluValid,
  output logic [ACC_W-1:0]                  outAcc,
  output logic                              outBusy,
  output logic                              outDone,
  output logic                              outOvf,
  output logic                              outErr,
  output logic [$clog2(MAX_DIGITS+1)-1:0]   outDigits
);

  // Width of the digit-append product: acc*RADIX + digit never wraps here,
  // so overflow past ACC_W bits can be detected from the upper bits.
  localparam int T_W   = ACC_W + $clog2(RADIX) + 1;
  localparam int DIG_W = $clog2(MAX_DIGITS + 1);

  localparam logic [T_W-1:0]   RADIX_T  = T_W'(RADIX);
  localparam logic [ACC_W-1:0] RADIX_A  = ACC_W'(RADIX);
  localparam logic [DIG_W-1:0] MAX_DIG  = DIG_W'(MAX_DIGITS);
  localparam logic [DIG_W-1:0] DIG_ZERO = {DIG_W{1'b0}};
  localparam logic [DIG_W-1:0] DIG_ONE  = {{(DIG_W-1){1'b0}}, 1'b1};
  localparam logic [ACC_W-1:0] ACC_ZERO = {ACC_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_WAIT_SRC = 2'b01,
    ST_COMMIT   = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    SEL_REG   = 2'b00,
    SEL_ALU   = 2'b01,
    SEL_DIGIT = 2'b10,
    SEL_CLEAR = 2'b11
  } sel_t;

  state_t             state_r;
  sel_t               selQ_r;
  logic [ACC_W-1:0]   opQ_r;
  logic [ACC_W-1:0]   acc_r;
  logic [DIG_W-1:0]   digits_r;
  logic               ovf_r;
  logic               err_r;
  logic               done_r;
  logic               busy_r;

  logic               srcValid_s;
  logic [ACC_W-1:0]   operand_s;
  logic [T_W-1:0]     appendSum_s;
  logic [ACC_W-1:0]   accNext_s;
  logic [DIG_W-1:0]   digitsNext_s;
  logic               ovfNext_s;
  logic               errNext_s;

  // acc*RADIX + digit, computed wide enough that it cannot wrap.
  function automatic logic [T_W-1:0] appendValue(
    input logic [ACC_W-1:0] acc,
    input logic [ACC_W-1:0] digit
  );
    appendValue = ({{(T_W-ACC_W){1'b0}}, acc} * RADIX_T)
                + {{(T_W-ACC_W){1'b0}}, digit};
  endfunction

  // Pick the valid strobe and the operand belonging to the latched select.
  always_comb begin
    srcValid_s = 1'b0;
    operand_s  = {{(ACC_W-IN_W){1'b0}}, inReg};
    case (selQ_r)
      SEL_ALU: begin
        srcValid_s = inAluValid;
        operand_s  = inAlu;
      end
      SEL_REG, SEL_DIGIT: begin
        srcValid_s = inRegValid;
        operand_s  = {{(ACC_W-IN_W){1'b0}}, inReg};
      end
      default: begin
        srcValid_s = 1'b0;
        operand_s  = {{(ACC_W-IN_W){1'b0}}, inReg};
      end
    endcase
  end

  // Values the accumulator, digit count and flags take when a command commits.
  always_comb begin
    appendSum_s  = appendValue(acc_r, opQ_r);
    accNext_s    = acc_r;
    digitsNext_s = digits_r;
    ovfNext_s    = ovf_r;
    errNext_s    = err_r;
    case (selQ_r)
      SEL_REG: begin
        accNext_s    = {{(ACC_W-IN_W){1'b0}}, opQ_r[IN_W-1:0]};
        digitsNext_s = DIG_ONE;
        ovfNext_s    = 1'b0;
        errNext_s    = 1'b0;
      end
      SEL_ALU: begin
        accNext_s    = opQ_r;
        digitsNext_s = DIG_ZERO;
      end
      SEL_CLEAR: begin
        accNext_s    = ACC_ZERO;
        digitsNext_s = DIG_ZERO;
        ovfNext_s    = 1'b0;
        errNext_s    = 1'b0;
      end
      SEL_DIGIT: begin
        // A bad digit takes precedence over overflow; both leave acc intact.
        if (opQ_r >= RADIX_A) begin
          errNext_s = 1'b1;
        end else if ((digits_r == MAX_DIG) ||
                     (appendSum_s[T_W-1:ACC_W] != {(T_W-ACC_W){1'b0}})) begin
          ovfNext_s = 1'b1;
        end else begin
          accNext_s    = appendSum_s[ACC_W-1:0];
          digitsNext_s = digits_r + DIG_ONE;
        end
      end
      default: begin
        accNext_s    = acc_r;
        digitsNext_s = digits_r;
      end
    endcase
  end

  // Command sequencer and registered outputs; reset aborts any command.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      selQ_r   <= SEL_REG;
      opQ_r    <= ACC_ZERO;
      acc_r    <= ACC_ZERO;
      digits_r <= DIG_ZERO;
      ovf_r    <= 1'b0;
      err_r    <= 1'b0;
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (inStart) begin
            selQ_r <= sel_t'(inSelect);
            busy_r <= 1'b1;
            // CLEAR needs no operand, so it skips the source wait.
            if (sel_t'(inSelect) == SEL_CLEAR) begin
              state_r <= ST_COMMIT;
            end else begin
              state_r <= ST_WAIT_SRC;
            end
          end else begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_WAIT_SRC: begin
          if (srcValid_s) begin
            opQ_r   <= operand_s;
            state_r <= ST_COMMIT;
          end else begin
            state_r <= ST_WAIT_SRC;
          end
        end
        ST_COMMIT: begin
          acc_r    <= accNext_s;
          digits_r <= digitsNext_s;
          ovf_r    <= ovfNext_s;
          err_r    <= errNext_s;
          done_r   <= 1'b1;
          busy_r   <= 1'b0;
          state_r  <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign outAcc    = acc_r;
  assign outBusy   = busy_r;
  assign outDone   = done_r;
  assign outOvf    = ovf_r;
  assign outErr    = err_r;
  assign outDigits = digits_r;

endmodule

// File: tb/tb_acc_src_mux.sv
// Bench for acc_src_mux: directed scenarios with literal expectations plus
// a randomized phase, all outputs compared every cycle against a
// transaction-level model of the accumulator.
module tb_acc_src_mux;

  localparam int IN_W = 4;
  localparam int ACC_W = 16;
  localparam int RADIX = 10;
  localparam int MAX_DIGITS = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              inStart = 1'b0;
  logic [1:0]        inSelect = 2'b00;
  logic [IN_W-1:0]   inReg = 4'h0;
  logic              inRegValid = 1'b0;
  logic [ACC_W-1:0]  inAlu = 16'h0000;
  logic              inAluValid = 1'b0;
  logic [ACC_W-1:0]  outAcc;
  logic              outBusy;
  logic              outDone;
  logic              outOvf;
  logic              outErr;
  logic [2:0]        outDigits;

  int nChecks = 0;
  int nFails = 0;
  bit checkEn = 1'b0;

  acc_src_mux #(.IN_W(IN_W), .ACC_W(ACC_W), .RADIX(RADIX), .MAX_DIGITS(MAX_DIGITS)) dut (
    .clk(clk), .reset(reset), .inStart(inStart), .inSelect(inSelect),
    .inReg(inReg), .inRegValid(inRegValid), .inAlu(inAlu), .inAluValid(inAluValid),
    .outAcc(outAcc), .outBusy(outBusy), .outDone(outDone), .outOvf(outOvf),
    .outErr(outErr), .outDigits(outDigits)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Transaction view: an accepted command knows the edge at which it must
  // complete (start edge + 1 for CLEAR, source-valid edge + 1 otherwise).
  int  edgeNo = 0;
  int  commitEdge = -1;
  bit  mBusy = 1'b0, mWaiting = 1'b0, mDone = 1'b0, mOvf = 1'b0, mErr = 1'b0;
  int  mSel = 0, mOp = 0, mAcc = 0, mDigits = 0;

  always @(posedge clk) begin
    edgeNo++;
    mDone = 1'b0;
    if (reset) begin
      mAcc = 0; mDigits = 0; mOvf = 1'b0; mErr = 1'b0;
      mBusy = 1'b0; mWaiting = 1'b0; commitEdge = -1;
    end else if (mBusy && edgeNo == commitEdge) begin
      case (mSel)
        0: begin mAcc = mOp % 16; mDigits = 1; mOvf = 1'b0; mErr = 1'b0; end
        1: begin mAcc = mOp; mDigits = 0; end
        2: begin
          if (mOp >= RADIX) mErr = 1'b1;
          else if (mDigits == MAX_DIGITS || mAcc * RADIX + mOp >= 65536) mOvf = 1'b1;
          else begin mAcc = mAcc * RADIX + mOp; mDigits++; end
        end
        default: begin mAcc = 0; mDigits = 0; mOvf = 1'b0; mErr = 1'b0; end
      endcase
      mDone = 1'b1; mBusy = 1'b0; commitEdge = -1;
    end else if (!mBusy) begin
      if (inStart) begin
        mBusy = 1'b1; mSel = int'(inSelect);
        if (mSel == 3) begin mWaiting = 1'b0; commitEdge = edgeNo + 1; end
        else mWaiting = 1'b1;
      end
    end else if (mWaiting) begin
      if ((mSel == 1) ? inAluValid : inRegValid) begin
        mOp = (mSel == 1) ? int'(inAlu) : int'(inReg);
        mWaiting = 1'b0; commitEdge = edgeNo + 1;
      end
    end
  end

  // Compare process: every output against the model on each falling edge.
  always @(negedge clk) begin
    if (checkEn) begin
      nChecks += 6;
      if (outAcc !== 16'(mAcc)) begin nFails++; $display("FAIL model_acc t=%0t: got %h expected %h", $time, outAcc, 16'(mAcc)); end
      if (outBusy !== mBusy) begin nFails++; $display("FAIL model_busy t=%0t: got %b expected %b", $time, outBusy, mBusy); end
      if (outDone !== mDone) begin nFails++; $display("FAIL model_done t=%0t: got %b expected %b", $time, outDone, mDone); end
      if (outOvf !== mOvf) begin nFails++; $display("FAIL model_ovf t=%0t: got %b expected %b", $time, outOvf, mOvf); end
      if (outErr !== mErr) begin nFails++; $display("FAIL model_err t=%0t: got %b expected %b", $time, outErr, mErr); end
      if (outDigits !== 3'(mDigits)) begin nFails++; $display("FAIL model_digits t=%0t: got %0d expected %0d", $time, outDigits, mDigits); end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one command; source data arrives after 'gap' idle cycles.
  // lat = edges from the start edge (counted as 1) to the done edge.
  task automatic runCmd(input logic [1:0] sel, input logic [15:0] val, input int gap, output int lat);
    bit got;
    inStart = 1'b1; inSelect = sel; tick(); inStart = 1'b0; lat = 1;
    if (sel != 2'b11) begin
      for (int i = 0; i < gap; i++) begin tick(); lat++; end
      if (sel == 2'b01) begin inAluValid = 1'b1; inAlu = val; end
      else begin inRegValid = 1'b1; inReg = val[3:0]; end
    end
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick(); lat++;
      inRegValid = 1'b0; inAluValid = 1'b0;
      if (outDone === 1'b1) got = 1'b1;
    end
    if (!got) begin
      nChecks++; nFails++;
      $display("FAIL done_timeout: got no done expected done within 40 cycles");
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int dones;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    checkEn = 1'b1;
    chk("reset_acc", 32'(outAcc), 32'h0);
    chk("reset_busy", 32'(outBusy), 32'h0);
    chk("reset_done", 32'(outDone), 32'h0);
    chk("reset_flags", {30'h0, outOvf, outErr}, 32'h0);
    chk("reset_digits", 32'(outDigits), 32'h0);

    // REG 7, valid in the cycle after start
    runCmd(2'b00, 16'h0007, 0, lat);
    chk("reg7_acc", 32'(outAcc), 32'h0007);
    chk("reg7_digits", 32'(outDigits), 32'd1);
    chk("reg7_latency", 32'(lat), 32'd3);

    // append 2,5,9 -> 7259, then a fifth digit overflows the count
    runCmd(2'b10, 16'd2, 1, lat);
    runCmd(2'b10, 16'd5, 0, lat);
    runCmd(2'b10, 16'd9, 3, lat);
    chk("append_acc", 32'(outAcc), 32'h1C5B);
    chk("append_digits", 32'(outDigits), 32'd4);
    runCmd(2'b10, 16'd1, 0, lat);
    chk("maxdig_ovf", 32'(outOvf), 32'h1);
    chk("maxdig_acc", 32'(outAcc), 32'h1C5B);

    // REG 9 clears ovf, 999 appended -> 9999; ALU FFF0 then append overflows width
    runCmd(2'b00, 16'd9, 0, lat);
    chk("reg_clears_ovf", 32'(outOvf), 32'h0);
    for (int k = 0; k < 3; k++) runCmd(2'b10, 16'd9, k, lat);
    chk("acc_9999", 32'(outAcc), 32'd9999);
    runCmd(2'b01, 16'hFFF0, 2, lat);
    chk("alu_acc", 32'(outAcc), 32'hFFF0);
    chk("alu_digits", 32'(outDigits), 32'd0);
    runCmd(2'b10, 16'd1, 0, lat);
    chk("width_ovf", 32'(outOvf), 32'h1);
    chk("width_acc", 32'(outAcc), 32'hFFF0);

    // invalid digit, then CLEAR with its 2-clock latency
    runCmd(2'b10, 16'h000C, 0, lat);
    chk("bad_digit_err", 32'(outErr), 32'h1);
    chk("bad_digit_acc", 32'(outAcc), 32'hFFF0);
    runCmd(2'b11, 16'h0, 0, lat);
    chk("clear_acc", 32'(outAcc), 32'h0);
    chk("clear_flags", {30'h0, outOvf, outErr}, 32'h0);
    chk("clear_latency", 32'(lat), 32'd2);

    // long ALU wait with an ignored second start
    inStart = 1'b1; inSelect = 2'b01; tick(); inStart = 1'b0;
    for (int i = 0; i < 20; i++) begin
      inStart = (i == 10); inSelect = 2'b11;
      tick();
    end
    inStart = 1'b0;
    chk("wait_busy", 32'(outBusy), 32'h1);
    inAluValid = 1'b1; inAlu = 16'h1234; tick(); inAluValid = 1'b0;
    dones = 0;
    for (int i = 0; i < 5; i++) begin tick(); if (outDone === 1'b1) dones++; end
    chk("single_done", 32'(dones), 32'd1);
    chk("wait_acc", 32'(outAcc), 32'h1234);

    // reset while waiting for the ALU aborts the command
    inStart = 1'b1; inSelect = 2'b01; tick(); inStart = 1'b0;
    tick();
    chk("abort_busy_before", 32'(outBusy), 32'h1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("abort_acc", 32'(outAcc), 32'h0);
    chk("abort_busy", 32'(outBusy), 32'h0);
    chk("abort_done", 32'(outDone), 32'h0);
    inAluValid = 1'b1; inAlu = 16'h5555; tick(); inAluValid = 1'b0; tick();
    chk("abort_no_done", 32'(outDone), 32'h0);
    chk("abort_acc_kept", 32'(outAcc), 32'h0);

    // randomized traffic, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 199) == 0);
      inStart    = ($urandom_range(0, 3) == 0);
      inSelect   = 2'($urandom_range(0, 3));
      inReg      = 4'($urandom_range(0, 15));
      inRegValid = ($urandom_range(0, 2) == 0);
      inAluValid = ($urandom_range(0, 2) == 0);
      inAlu      = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 7000)) : 16'($urandom);
      tick();
    end
    reset = 1'b0; inStart = 1'b0; inRegValid = 1'b0; inAluValid = 1'b0;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
